// File: rtl/pointer_sequencer.sv
// pointer_sequencer: fetch/execute control for the IP/DP pointer pair with a load/store accumulator.
// Define POINTER_SEQUENCER_ILLEGAL_TRAP_EN to halt on undefined opcodes instead of treating them as NOP.
module pointer_sequencer #(
    parameter logic [7:0] HLT_OPCODE = 8'hFF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic [7:0] mem_di,
    output logic       oe_addr_ip,
    output logic       oe_addr_dp,
    output logic       oe_dl,
    output logic       oe_dh,
    output logic       cnt,
    output logic       we_l,
    output logic       we_h,
    output logic       selector,
    output logic       mem_we_n,
    output logic       acc_oe_n,
    output logic [7:0] acc,
    output logic [7:0] opcode,
    output logic       halted
);
    typedef enum logic [1:0] {FETCH, EXEC, EXEC2, HALT} state_t;
    state_t     state_q, state_d;
    logic [7:0] opcode_q, opcode_d, acc_q, acc_d;
    logic       selector_q, selector_d;
    logic       ip_n, dp_n, cnt_c, wl_n, wh_n, mw_n, ao_n;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= FETCH;
            opcode_q   <= 8'h00;
            acc_q      <= 8'h00;
            selector_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            opcode_q   <= opcode_d;
            acc_q      <= acc_d;
            selector_q <= selector_d;
        end
    end
    always_comb begin
        state_d    = state_q;
        opcode_d   = opcode_q;
        acc_d      = acc_q;
        selector_d = selector_q;
        ip_n       = 1'b1;
        dp_n       = 1'b1;
        cnt_c      = 1'b0;
        wl_n       = 1'b1;
        wh_n       = 1'b1;
        mw_n       = 1'b1;
        ao_n       = 1'b1;
        case (state_q)
            FETCH: begin
                ip_n  = 1'b0;
                cnt_c = 1'b1;
                if (ready) begin
                    opcode_d = mem_di;
                    state_d  = (mem_di == HLT_OPCODE) ? HALT : EXEC;
                end
            end
            EXEC: begin
                if (ready) state_d = FETCH;
                case (opcode_q)
                    8'h01: if (ready) selector_d = !selector_q;
                    8'h02: begin
                        ip_n  = 1'b0;
                        wl_n  = 1'b0;
                        cnt_c = 1'b1;
                        if (ready) state_d = EXEC2;
                    end
                    8'h03: begin
                        dp_n = 1'b0;
                        if (ready) acc_d = mem_di;
                    end
                    8'h04: begin
                        dp_n = 1'b0;
                        ao_n = 1'b0;
                        mw_n = 1'b0;
                    end
                    default: ;
                endcase
`ifdef POINTER_SEQUENCER_ILLEGAL_TRAP_EN
                if (ready && opcode_q > 8'h04) state_d = HALT;
`endif
            end
            EXEC2: begin
                ip_n  = 1'b0;
                wh_n  = 1'b0;
                cnt_c = 1'b1;
                if (ready) state_d = FETCH;
            end
            default: ;
        endcase
    end
    // Address enables stay asserted through wait states; edge-acting strobes are masked until ready.
    assign oe_addr_ip = ip_n | rst;
    assign oe_addr_dp = dp_n | rst;
    assign oe_dl      = 1'b1;
    assign oe_dh      = 1'b1;
    assign cnt        = cnt_c & ready & !rst;
    assign we_l       = wl_n | !ready | rst;
    assign we_h       = wh_n | !ready | rst;
    assign mem_we_n   = mw_n | !ready | rst;
    assign acc_oe_n   = ao_n | rst;
    assign selector   = selector_q;
    assign acc        = acc_q;
    assign opcode     = opcode_q;
    assign halted     = (state_q == HALT) && !rst;
endmodule

// File: tb/tb_pointer_sequencer.sv
// tb_pointer_sequencer: drives a small program through a model IP/DP pair and memory,
// scoreboarding the per-cycle strobe/register/bus picture.
module tb_pointer_sequencer;
    logic        clk = 1'b0, rst = 1'b1, ready = 1'b1;
    logic [7:0]  mem_di, acc, opcode, bus;
    logic        oe_addr_ip, oe_addr_dp, oe_dl, oe_dh, cnt, we_l, we_h, selector, mem_we_n, acc_oe_n, halted;
    logic [7:0]  mem [256];
    logic [15:0] r [2];
    logic [15:0] ip, dp, addr;
    logic [34:0] obs;
    typedef struct {string tag; logic [34:0] v;} exp_t;
    exp_t sb [$];
    int total = 0, bad = 0;
    logic [7:0] a_exp, op_prev;

    pointer_sequencer dut (
        .clk(clk), .rst(rst), .ready(ready), .mem_di(mem_di),
        .oe_addr_ip(oe_addr_ip), .oe_addr_dp(oe_addr_dp), .oe_dl(oe_dl), .oe_dh(oe_dh),
        .cnt(cnt), .we_l(we_l), .we_h(we_h), .selector(selector),
        .mem_we_n(mem_we_n), .acc_oe_n(acc_oe_n), .acc(acc), .opcode(opcode), .halted(halted)
    );

    always #5 clk = ~clk;

    always_comb begin
        ip     = r[selector];
        dp     = r[~selector];
        addr   = !oe_addr_ip ? ip : (!oe_addr_dp ? dp : 16'h0000);
        mem_di = (!oe_addr_ip || !oe_addr_dp) ? mem[addr[7:0]] : 8'hEE;
        bus    = acc_oe_n ? mem_di : acc;
        obs    = {oe_addr_ip, oe_addr_dp, oe_dl, oe_dh, cnt, we_l, we_h, selector,
                  mem_we_n, acc_oe_n, halted, acc, opcode, bus};
    end

    // Pointer pair and memory model reacting to the strobes
    always @(posedge clk) begin
        if (!rst) begin
            if (cnt) r[selector] <= r[selector] + 16'd1;
            if (!we_l) r[~selector][7:0] <= mem_di;
            if (!we_h) r[~selector][15:8] <= mem_di;
            if (!mem_we_n) mem[addr[7:0]] <= bus;
        end
    end

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [34:0] ev(input logic ipn, dpn, c, wl, wh, sel, mw, ao, h,
                                       input logic [7:0] a, op, b);
        return {ipn, dpn, 2'b11, c, wl, wh, sel, mw, ao, h, a, op, b};
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t x;
            x = sb.pop_front();
            chk(x.tag, obs, x.v);
        end
    end

    task automatic cyc(input string tag, input logic [34:0] e);
        sb.push_back('{tag, e});
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        r[0] = 16'h0000;
        r[1] = 16'h0000;
        mem[8'h00] = 8'h02; mem[8'h01] = 8'h34; mem[8'h02] = 8'h12;
        mem[8'h03] = 8'h03;
        mem[8'h04] = 8'h02; mem[8'h05] = 8'h41; mem[8'h06] = 8'h00;
        mem[8'h07] = 8'h04;
        mem[8'h08] = 8'h02; mem[8'h09] = 8'h50; mem[8'h0A] = 8'h00;
        mem[8'h0B] = 8'h01;
        mem[8'h0C] = 8'h00;
        mem[8'h0D] = 8'h03;
        mem[8'h0E] = 8'h7E;
        mem[8'h0F] = 8'hFF;
        mem[8'h10] = 8'h02; mem[8'h11] = 8'h66; mem[8'h12] = 8'h77;
        mem[8'h34] = 8'h5A;
        mem[8'h50] = 8'h01;
        mem[8'h51] = 8'hA5;
        @(posedge clk);
        #1;
        cyc("rst", ev(1,1,0,1,1,0,1,1,0,8'h00,8'h00,8'hEE));
        rst = 1'b0;
        cyc("ldp_f",  ev(0,1,1,1,1,0,1,1,0,8'h00,8'h00,8'h02));
        cyc("ldp_l",  ev(0,1,1,0,1,0,1,1,0,8'h00,8'h02,8'h34));
        cyc("ldp_h",  ev(0,1,1,1,0,0,1,1,0,8'h00,8'h02,8'h12));
        chk("ip_after_ldp", {19'd0, ip}, 35'h3);
        chk("dp_after_ldp", {19'd0, dp}, 35'h1234);
        cyc("lda_f",  ev(0,1,1,1,1,0,1,1,0,8'h00,8'h02,8'h03));
        cyc("lda_x",  ev(1,0,0,1,1,0,1,1,0,8'h00,8'h03,8'h5A));
        cyc("ldp2_f", ev(0,1,1,1,1,0,1,1,0,8'h5A,8'h03,8'h02));
        cyc("ldp2_l", ev(0,1,1,0,1,0,1,1,0,8'h5A,8'h02,8'h41));
        cyc("ldp2_h", ev(0,1,1,1,0,0,1,1,0,8'h5A,8'h02,8'h00));
        cyc("sta_f",  ev(0,1,1,1,1,0,1,1,0,8'h5A,8'h02,8'h04));
        cyc("sta_x",  ev(1,0,0,1,1,0,0,0,0,8'h5A,8'h04,8'h5A));
        chk("sta_mem", {27'd0, mem[8'h41]}, 35'h5A);
        cyc("ldp3_f", ev(0,1,1,1,1,0,1,1,0,8'h5A,8'h04,8'h02));
        cyc("ldp3_l", ev(0,1,1,0,1,0,1,1,0,8'h5A,8'h02,8'h50));
        cyc("ldp3_h", ev(0,1,1,1,0,0,1,1,0,8'h5A,8'h02,8'h00));
        cyc("swp1_f", ev(0,1,1,1,1,0,1,1,0,8'h5A,8'h02,8'h01));
        cyc("swp1_x", ev(1,1,0,1,1,0,1,1,0,8'h5A,8'h01,8'hEE));
        cyc("swp2_f", ev(0,1,1,1,1,1,1,1,0,8'h5A,8'h01,8'h01));
        cyc("swp2_x", ev(1,1,0,1,1,1,1,1,0,8'h5A,8'h01,8'hEE));
        cyc("nop_f",  ev(0,1,1,1,1,0,1,1,0,8'h5A,8'h01,8'h00));
        cyc("nop_x",  ev(1,1,0,1,1,0,1,1,0,8'h5A,8'h00,8'hEE));
        chk("ip_pre_wait", {19'd0, ip}, 35'hD);
        ready = 1'b0;
        for (int i = 0; i < 3; i++)
            cyc("wait_f", ev(0,1,0,1,1,0,1,1,0,8'h5A,8'h00,8'h03));
        chk("ip_in_wait", {19'd0, ip}, 35'hD);
        ready = 1'b1;
        cyc("lda2_f", ev(0,1,1,1,1,0,1,1,0,8'h5A,8'h00,8'h03));
        chk("ip_post_wait", {19'd0, ip}, 35'hE);
        cyc("lda2_x", ev(1,0,0,1,1,0,1,1,0,8'h5A,8'h03,8'hA5));
        cyc("ill_f",  ev(0,1,1,1,1,0,1,1,0,8'hA5,8'h03,8'h7E));
`ifdef POINTER_SEQUENCER_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++)
            cyc("ill_halt", ev(1,1,0,1,1,0,1,1,1,8'hA5,8'h7E,8'hEE));
        rst = 1'b1;
        cyc("ill_rst", ev(1,1,0,1,1,0,1,1,0,8'h00,8'h00,8'hEE));
        rst = 1'b0;
        a_exp = 8'h00;
        op_prev = 8'h00;
`else
        cyc("ill_nop", ev(1,1,0,1,1,0,1,1,0,8'hA5,8'h7E,8'hEE));
        a_exp = 8'hA5;
        op_prev = 8'h7E;
`endif
        cyc("hlt_f", ev(0,1,1,1,1,0,1,1,0,a_exp,op_prev,8'hFF));
        for (int i = 0; i < 10; i++) begin
            ready = 1'($urandom_range(0, 1));
            cyc("halt", ev(1,1,0,1,1,0,1,1,1,a_exp,8'hFF,8'hEE));
        end
        ready = 1'b1;
        rst = 1'b1;
        cyc("halt_rst", ev(1,1,0,1,1,0,1,1,0,8'h00,8'h00,8'hEE));
        rst = 1'b0;
        cyc("ldp4_f", ev(0,1,1,1,1,0,1,1,0,8'h00,8'h00,8'h02));
        cyc("ldp4_l", ev(0,1,1,0,1,0,1,1,0,8'h00,8'h02,8'h66));
        @(negedge clk);
        chk("exec2_weh", {34'd0, we_h}, 35'h0);
        rst = 1'b1;
        #1;
        chk("async_weh", {34'd0, we_h}, 35'h1);
        chk("async_cnt", {34'd0, cnt}, 35'h0);
        chk("async_oe_ip", {34'd0, oe_addr_ip}, 35'h1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("post_rst_f", ev(0,1,1,1,1,0,1,1,0,8'h00,8'h00,8'h77));
        @(negedge clk);
        #1;
        chk("sb_empty", 35'(sb.size()), 35'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
